// File: rtl/mem_port_arbiter.sv
// Shares one memory request port between an instruction fetch requester and
// a load/store requester, with at most one transaction in flight.
// Optional build macro MEM_ARB_RR_EN: alternate grants on simultaneous
// requests instead of giving the load/store side fixed priority.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    state_t state;
    owner_t owner;
    logic   grant_data;
    logic   addr_acc;
    logic   resp_vld;

`ifdef MEM_ARB_RR_EN
    owner_t last_grant;

    // On a tie, favour whichever side was not granted last time
    always_comb begin
        grant_data = data_req;
        if (inst_req && data_req) begin
            grant_data = (last_grant == OWN_INST);
        end
    end

    // Remember the most recent grant; starts at inst so the first tie goes to data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= OWN_INST;
        end else if (state == IDLE && (inst_req || data_req)) begin
            last_grant <= grant_data ? OWN_DATA : OWN_INST;
        end
    end
`else
    // Load/store side wins whenever it is requesting
    always_comb begin
        grant_data = data_req;
    end
`endif

    // Transaction FSM; the memory-side request and payload are registered at grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            owner     <= OWN_INST;
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wstrb <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_req || data_req) begin
                        state   <= ADDR;
                        mem_req <= 1'b1;
                        if (grant_data) begin
                            owner     <= OWN_DATA;
                            mem_wr    <= data_wr;
                            mem_wstrb <= data_wstrb;
                            mem_addr  <= data_addr;
                            mem_wdata <= data_wdata;
                        end else begin
                            owner     <= OWN_INST;
                            mem_wr    <= 1'b0;
                            mem_wstrb <= 4'h0;
                            mem_addr  <= inst_addr;
                            mem_wdata <= 32'h0;
                        end
                    end
                end
                ADDR: begin
                    // Payload is held even if the owner drops its request early
                    if (mem_addr_ok) begin
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_wr    <= 1'b0;
                        mem_wstrb <= 4'h0;
                        mem_addr  <= 32'h0;
                        mem_wdata <= 32'h0;
                    end
                end
                RESP: begin
                    if (mem_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Handshakes pass straight through to the current owner only
    always_comb begin
        addr_acc     = (state == ADDR) && mem_addr_ok;
        resp_vld     = (state == RESP) && mem_data_ok;
        inst_addr_ok = addr_acc && (owner == OWN_INST);
        data_addr_ok = addr_acc && (owner == OWN_DATA);
        inst_data_ok = resp_vld && (owner == OWN_INST);
        data_data_ok = resp_vld && (owner == OWN_DATA);
        inst_rdata   = inst_data_ok ? mem_rdata : 32'h0;
        data_rdata   = data_data_ok ? mem_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_wr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;
    logic [31:0] mem_rdata;

    logic [137:0] all_outs;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    assign all_outs = {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
                       inst_addr_ok, inst_data_ok, inst_rdata,
                       data_addr_ok, data_data_ok, data_rdata};

    always #5 clk = ~clk;

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst_req    = 1'b0;
        inst_addr   = 32'h0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_wstrb  = 4'h0;
        data_addr   = 32'h0;
        data_wdata  = 32'h0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        mem_rdata   = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        resetn      = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'h1000_0000;
        data_req    = 1'b1;
        data_wr     = 1'b1;
        data_wstrb  = 4'hf;
        data_addr   = 32'h8000_0000;
        data_wdata  = 32'hffff_ffff;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hdead_beef;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (all_outs !== 138'h0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %h expected 0", i, all_outs);
            end
            step();
        end
        // release with inst_req already waiting; grant on the first live edge
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b0;
        resetn      = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_mem_req: got %b expected 0", mem_req);
        end
        step();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h1000_0000}) begin
            errors++;
            $display("FAIL first_grant: got req=%b addr=%h expected req=1 addr=10000000", mem_req, mem_addr);
        end
        mem_addr_ok = 1'b1;
        step();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        step();
        mem_data_ok = 1'b0;
        step();
    endtask

    task automatic test_inst_fetch();
        idle_inputs();
        inst_req  = 1'b1;
        inst_addr = 32'hbfc0_0000;
        #1;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_idle_mem_req: got %b expected 0", mem_req);
        end
        step();
        // first ADDR cycle: memory not ready yet
        checks++;
        if ({mem_req, mem_wr, mem_addr, inst_addr_ok} !== {1'b1, 1'b0, 32'hbfc0_0000, 1'b0}) begin
            errors++;
            $display("FAIL fetch_addr_phase: got req=%b wr=%b addr=%h aok=%b expected 1 0 bfc00000 0",
                     mem_req, mem_wr, mem_addr, inst_addr_ok);
        end
        step();
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_addr_ok: got inst=%b data=%b expected 1 0", inst_addr_ok, data_addr_ok);
        end
        step();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h3c1d_0001;
        #1;
        checks++;
        if ({inst_data_ok, inst_rdata, data_data_ok, mem_req} !== {1'b1, 32'h3c1d_0001, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_data_ok: got dok=%b rdata=%h ddok=%b req=%b expected 1 3c1d0001 0 0",
                     inst_data_ok, inst_rdata, data_data_ok, mem_req);
        end
        step();
        mem_data_ok = 1'b0;
        #1;
        checks++;
        if ({inst_data_ok, inst_rdata} !== {1'b0, 32'h0}) begin
            errors++;
            $display("FAIL fetch_data_ok_one_cycle: got dok=%b rdata=%h expected 0 0", inst_data_ok, inst_rdata);
        end
        step();
    endtask

    task automatic test_tie_priority();
        idle_inputs();
        inst_req   = 1'b1;
        inst_addr  = 32'hbfc0_0004;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'hf;
        data_addr  = 32'h8000_1000;
        data_wdata = 32'h1234_5678;
        step();
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, data_addr_ok, inst_addr_ok} !==
            {1'b1, 1'b1, 4'hf, 32'h8000_1000, 32'h1234_5678, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tie_first_data: got req=%b wr=%b strb=%h addr=%h wdata=%h daok=%b iaok=%b expected 1 1 f 80001000 12345678 1 0",
                     mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, data_addr_ok, inst_addr_ok);
        end
        step();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0000_0000;
        #1;
        checks++;
        if ({data_data_ok, inst_data_ok} !== 2'b10) begin
            errors++;
            $display("FAIL tie_first_data_ok: got data=%b inst=%b expected 1 0", data_data_ok, inst_data_ok);
        end
        step();
        mem_data_ok = 1'b0;
        step();
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if ({mem_wr, mem_addr, inst_addr_ok, data_addr_ok} !== {1'b0, 32'hbfc0_0004, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tie_second_inst: got wr=%b addr=%h iaok=%b daok=%b expected 0 bfc00004 1 0",
                     mem_wr, mem_addr, inst_addr_ok, data_addr_ok);
        end
        step();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h2408_0005;
        #1;
        checks++;
        if ({inst_data_ok, inst_rdata, data_data_ok} !== {1'b1, 32'h2408_0005, 1'b0}) begin
            errors++;
            $display("FAIL tie_second_data_ok: got idok=%b rdata=%h ddok=%b expected 1 24080005 0",
                     inst_data_ok, inst_rdata, data_data_ok);
        end
        step();
        mem_data_ok = 1'b0;
        step();
    endtask

    // Both sides keep requesting, so every arbitration is a tie
    task automatic test_tie_repeat();
        bit rr;
        bit prev_inst;
        bit exp_data;
`ifdef MEM_ARB_RR_EN
        rr = 1'b1;
`else
        rr = 1'b0;
`endif
        prev_inst = 1'b1;
        idle_inputs();
        inst_req   = 1'b1;
        inst_addr  = 32'hbfc0_0040;
        data_req   = 1'b1;
        data_wr    = 1'b0;
        data_wstrb = 4'h3;
        data_addr  = 32'h8000_2000;
        for (int k = 0; k < 4; k++) begin
            exp_data = rr ? prev_inst : 1'b1;
            step();
            mem_addr_ok = 1'b1;
            #1;
            checks++;
            if ({data_addr_ok, inst_addr_ok, mem_addr} !==
                {exp_data, !exp_data, exp_data ? 32'h8000_2000 : 32'hbfc0_0040}) begin
                errors++;
                $display("FAIL tie_repeat_grant %0d: got daok=%b iaok=%b addr=%h expected data=%b",
                         k, data_addr_ok, inst_addr_ok, mem_addr, exp_data);
            end
            step();
            mem_addr_ok = 1'b0;
            mem_data_ok = 1'b1;
            mem_rdata   = 32'h100 + 32'(k);
            if (k == 3) begin
                inst_req = 1'b0;
                data_req = 1'b0;
            end
            #1;
            checks++;
            if ({data_data_ok, inst_data_ok} !== {exp_data, !exp_data}) begin
                errors++;
                $display("FAIL tie_repeat_data_ok %0d: got data=%b inst=%b expected data=%b",
                         k, data_data_ok, inst_data_ok, exp_data);
            end
            prev_inst = !exp_data;
            step();
            mem_data_ok = 1'b0;
        end
        step();
    endtask

    task automatic test_addr_stall();
        idle_inputs();
        inst_req  = 1'b1;
        inst_addr = 32'hbfc0_0100;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                data_req   = 1'b1;
                data_wr    = 1'b1;
                data_wstrb = 4'h1;
                data_addr  = 32'h8000_4000;
                data_wdata = 32'h0000_00aa;
            end
            if (i == 3) begin
                inst_req = 1'b0;
            end
            #1;
            checks++;
            if ({mem_req, mem_wr, mem_addr, inst_addr_ok, data_addr_ok} !==
                {1'b1, 1'b0, 32'hbfc0_0100, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold %0d: got req=%b wr=%b addr=%h iaok=%b daok=%b expected 1 0 bfc00100 0 0",
                         i, mem_req, mem_wr, mem_addr, inst_addr_ok, data_addr_ok);
            end
            step();
        end
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin
            errors++;
            $display("FAIL stall_accept: got iaok=%b daok=%b expected 1 0", inst_addr_ok, data_addr_ok);
        end
        step();
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h0bad_f00d;
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b10) begin
            errors++;
            $display("FAIL stall_inst_data_ok: got inst=%b data=%b expected 1 0", inst_data_ok, data_data_ok);
        end
        step();
        mem_data_ok = 1'b0;
        step();
        mem_addr_ok = 1'b1;
        #1;
        checks++;
        if ({data_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata} !==
            {1'b1, 1'b1, 4'h1, 32'h8000_4000, 32'h0000_00aa}) begin
            errors++;
            $display("FAIL stall_then_data: got daok=%b wr=%b strb=%h addr=%h wdata=%h expected 1 1 1 80004000 000000aa",
                     data_addr_ok, mem_wr, mem_wstrb, mem_addr, mem_wdata);
        end
        step();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'h5555_aaaa;
        #1;
        checks++;
        if ({data_data_ok, data_rdata} !== {1'b1, 32'h5555_aaaa}) begin
            errors++;
            $display("FAIL stall_data_data_ok: got dok=%b rdata=%h expected 1 5555aaaa", data_data_ok, data_rdata);
        end
        step();
        mem_data_ok = 1'b0;
        step();
    endtask

    task automatic test_reset_in_resp();
        idle_inputs();
        data_req  = 1'b1;
        data_addr = 32'h8000_3000;
        step();
        mem_addr_ok = 1'b1;
        step();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        resetn      = 1'b0;
        #1;
        checks++;
        if (all_outs !== 138'h0) begin
            errors++;
            $display("FAIL resp_reset_outputs: got %h expected 0", all_outs);
        end
        step();
        resetn      = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = 32'hcafe_0001;
        #1;
        checks++;
        if ({inst_data_ok, data_data_ok, data_rdata, inst_rdata, mem_req} !== 67'h0) begin
            errors++;
            $display("FAIL resp_reset_no_data_ok: got idok=%b ddok=%b drdata=%h irdata=%h req=%b expected all 0",
                     inst_data_ok, data_data_ok, data_rdata, inst_rdata, mem_req);
        end
        step();
        mem_data_ok = 1'b0;
        inst_req    = 1'b1;
        inst_addr   = 32'hbfc0_0200;
        step();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'hbfc0_0200}) begin
            errors++;
            $display("FAIL resp_reset_back_idle: got req=%b addr=%h expected 1 bfc00200", mem_req, mem_addr);
        end
        mem_addr_ok = 1'b1;
        step();
        inst_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        step();
        mem_data_ok = 1'b0;
        step();
    endtask

    task automatic test_spurious();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            mem_data_ok = 1'b1;
            mem_rdata   = $urandom;
            #1;
            checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata, mem_req} !== 67'h0) begin
                errors++;
                $display("FAIL spurious_idle %0d: got idok=%b ddok=%b irdata=%h drdata=%h req=%b expected all 0",
                         i, inst_data_ok, data_data_ok, inst_rdata, data_rdata, mem_req);
            end
            step();
        end
        mem_data_ok = 1'b0;
        data_req    = 1'b1;
        data_addr   = 32'h8000_5000;
        step();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 32'h8000_5000}) begin
            errors++;
            $display("FAIL spurious_still_idle: got req=%b addr=%h expected 1 80005000", mem_req, mem_addr);
        end
        mem_addr_ok = 1'b1;
        step();
        data_req    = 1'b0;
        mem_addr_ok = 1'b0;
        mem_data_ok = 1'b1;
        step();
        mem_data_ok = 1'b0;
        step();
    endtask

    // Random traffic: each accepted address must carry the accepted side's
    // payload, and each response must go to the side whose address was
    // accepted last, with no second acceptance while one is outstanding.
    task automatic test_random();
        int  inst_left;
        int  data_left;
        int  served;
        int  cyc;
        bit  outstanding;
        bit  out_data;
        bit  drop_inst;
        bit  drop_data;
        bit  acc;
        bit  exp_idok;
        bit  exp_ddok;
        idle_inputs();
        inst_left   = 40;
        data_left   = 40;
        served      = 0;
        cyc         = 0;
        outstanding = 1'b0;
        out_data    = 1'b0;
        drop_inst   = 1'b0;
        drop_data   = 1'b0;
        while ((inst_left > 0 || data_left > 0 || inst_req || data_req || outstanding) && cyc < 4000) begin
            if (drop_inst) inst_req = 1'b0;
            if (drop_data) data_req = 1'b0;
            drop_inst = 1'b0;
            drop_data = 1'b0;
            if (!inst_req && inst_left > 0 && $urandom_range(0, 3) == 0) begin
                inst_req  = 1'b1;
                inst_addr = $urandom;
                inst_left--;
            end
            if (!data_req && data_left > 0 && $urandom_range(0, 3) == 0) begin
                data_req   = 1'b1;
                data_wr    = 1'($urandom_range(0, 1));
                data_wstrb = 4'($urandom);
                data_addr  = $urandom;
                data_wdata = $urandom;
                data_left--;
            end
            mem_addr_ok = 1'($urandom_range(0, 1));
            mem_rdata   = $urandom;
            if (outstanding) mem_data_ok = ($urandom_range(0, 2) == 0);
            else             mem_data_ok = ($urandom_range(0, 7) == 0);
            #1;
            acc = mem_req && mem_addr_ok;
            checks++;
            if ((inst_addr_ok | data_addr_ok) !== acc || (inst_addr_ok & data_addr_ok) !== 1'b0) begin
                errors++;
                $display("FAIL rnd_addr_ok cyc %0d: got iaok=%b daok=%b expected one of them = %b",
                         cyc, inst_addr_ok, data_addr_ok, acc);
            end
            if (outstanding) begin
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_one_outstanding cyc %0d: got mem_req=%b expected 0", cyc, mem_req);
                end
            end
            if (inst_addr_ok === 1'b1) begin
                checks++;
                if ({inst_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, 1'b0, 4'h0, inst_addr, 32'h0}) begin
                    errors++;
                    $display("FAIL rnd_inst_payload cyc %0d: got req=%b wr=%b strb=%h addr=%h wdata=%h expected 1 0 0 %h 0",
                             cyc, inst_req, mem_wr, mem_wstrb, mem_addr, mem_wdata, inst_addr);
                end
            end
            if (data_addr_ok === 1'b1) begin
                checks++;
                if ({data_req, mem_wr, mem_wstrb, mem_addr, mem_wdata} !== {1'b1, data_wr, data_wstrb, data_addr, data_wdata}) begin
                    errors++;
                    $display("FAIL rnd_data_payload cyc %0d: got wr=%b strb=%h addr=%h wdata=%h expected %b %h %h %h",
                             cyc, mem_wr, mem_wstrb, mem_addr, mem_wdata, data_wr, data_wstrb, data_addr, data_wdata);
                end
            end
            exp_idok = mem_data_ok && outstanding && !out_data;
            exp_ddok = mem_data_ok && outstanding && out_data;
            checks++;
            if ({inst_data_ok, data_data_ok, inst_rdata, data_rdata} !==
                {exp_idok, exp_ddok, exp_idok ? mem_rdata : 32'h0, exp_ddok ? mem_rdata : 32'h0}) begin
                errors++;
                $display("FAIL rnd_response cyc %0d: got idok=%b ddok=%b irdata=%h drdata=%h expected %b %b rdata=%h",
                         cyc, inst_data_ok, data_data_ok, inst_rdata, data_rdata, exp_idok, exp_ddok, mem_rdata);
            end
            if (exp_idok || exp_ddok) begin
                outstanding = 1'b0;
                served++;
            end
            if (inst_addr_ok === 1'b1 || data_addr_ok === 1'b1) begin
                outstanding = 1'b1;
                out_data    = (data_addr_ok === 1'b1);
                drop_inst   = (inst_addr_ok === 1'b1);
                drop_data   = (data_addr_ok === 1'b1);
            end
            step();
            cyc++;
        end
        checks++;
        if (served !== 80) begin
            errors++;
            $display("FAIL rnd_completion: got %0d served after %0d cycles expected 80", served, cyc);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        step();
        test_reset();
        test_inst_fetch();
        test_tie_priority();
        test_tie_repeat();
        test_addr_stall();
        test_reset_in_resp();
        test_spurious();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
